// File: rtl/clock12_pkg.sv
// Shared types and constants for the 12-hour timekeeping core.
package clock12_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX     = 4'd9;

    localparam bcd_t RST_HR_TENS  = 4'd1;
    localparam bcd_t RST_HR_ONES  = 4'd2;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD 00..59 counter with synchronous clear and same-cycle carry.
module bcd_mod60_counter
    import clock12_pkg::*;
#(
    parameter bcd_t TENS_MAX = 4'd5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    // Carry is combinational so the next stage advances on the same edge.
    assign carry = inc && (tens == TENS_MAX) && (ones == ONES_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == ONES_MAX) begin
                ones <= '0;
                tens <= (tens == TENS_MAX) ? '0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock12_time_counter.sv
// 12-hour clock core: 1 Hz prescaler, sec/min/hour BCD counters, AM/PM and set mode.
// Define CLOCK12_EXT_TICK_EN to replace the prescaler with an external tick_in enable.
module clock12_time_counter
    import clock12_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic set_mode,
    input  logic inc_hr,
    input  logic inc_min,
`ifdef CLOCK12_EXT_TICK_EN
    input  logic tick_in,
`endif
    output bcd_t hr_tens,
    output bcd_t hr_ones,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic pm,
    output logic sec_pulse
);

    logic tick;

`ifdef CLOCK12_EXT_TICK_EN
    assign tick = tick_in & ~set_mode;
`else
    localparam int unsigned PW = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ_HZ - 1);

    logic [PW-1:0] presc;

    // Held at zero in set mode so the first tick after exit is a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (set_mode || (presc == PRESC_TC)) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = ~set_mode & (presc == PRESC_TC);
`endif

    // [0] samples the input, [1] holds the previous sample.
    logic [1:0] hr_edge;
    logic [1:0] min_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_edge  <= '0;
            min_edge <= '0;
        end else begin
            hr_edge  <= {hr_edge[0], inc_hr};
            min_edge <= {min_edge[0], inc_min};
        end
    end

    logic hr_rise;
    logic min_rise;

    assign hr_rise  = set_mode & hr_edge[0] & ~hr_edge[1];
    assign min_rise = set_mode & min_edge[0] & ~min_edge[1];

    logic sec_carry;
    logic min_carry;
    logic min_inc;
    logic hr_adv;

    bcd_mod60_counter #(
        .TENS_MAX (SEC_TENS_MAX)
    ) u_sec (
        .clk   (clk),
        .rst   (rst),
        .clr   (set_mode),
        .inc   (tick),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    // Set-mode minute edits never ripple into the hours.
    assign min_inc = set_mode ? min_rise : sec_carry;
    assign hr_adv  = set_mode ? hr_rise  : min_carry;

    bcd_mod60_counter #(
        .TENS_MAX (MIN_TENS_MAX)
    ) u_min (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (min_inc),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

    bcd_t hr_tens_nx;
    bcd_t hr_ones_nx;
    logic pm_nx;

    // Hours run 12 -> 01 -> ... -> 11 -> 12; AM/PM flips only entering 12.
    always_comb begin
        hr_tens_nx = hr_tens;
        hr_ones_nx = hr_ones;
        pm_nx      = pm;
        if (hr_adv) begin
            if ((hr_tens == 4'd1) && (hr_ones == 4'd2)) begin
                hr_tens_nx = 4'd0;
                hr_ones_nx = 4'd1;
            end else if ((hr_tens == 4'd1) && (hr_ones == 4'd1)) begin
                hr_tens_nx = 4'd1;
                hr_ones_nx = 4'd2;
                pm_nx      = ~pm;
            end else if (hr_ones == ONES_MAX) begin
                hr_tens_nx = 4'd1;
                hr_ones_nx = 4'd0;
            end else begin
                hr_ones_nx = hr_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_tens   <= RST_HR_TENS;
            hr_ones   <= RST_HR_ONES;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            hr_tens   <= hr_tens_nx;
            hr_ones   <= hr_ones_nx;
            pm        <= pm_nx;
            sec_pulse <= tick;
        end
    end

endmodule
